// File: rtl/mux_share_arbiter.sv
// Round-robin owner of a shared 2:1 lane, bursts capped at MAX_BURST beats; grant is one cycle after request.
// ready=0 freezes grant and beat count indefinitely; out_valid/out_data are combinational from grant state.
module mux_share_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic             last_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    input  logic             last_b,
    input  logic             ready,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel_b1,
    output logic             sel_b2,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(MAX_BURST - 1);

    state_t     state;
    state_t     state_nxt;
    logic       prio_b;
    logic       prio_b_nxt;
    logic [7:0] beat_cnt;
    logic [7:0] beat_cnt_nxt;
    logic       beat;
    logic       cur_last;
    logic       cur_req;
    logic       rearb;

    assign out_valid = (gnt_a & req_a) | (gnt_b & req_b);
    assign out_data  = (sel_b1 & sel_b2) ? data_b : data_a;
    assign beat      = out_valid & ready;
    assign cur_last  = gnt_b ? last_b : last_a;
    assign cur_req   = gnt_b ? req_b : req_a;

    always_comb begin
        rearb        = 1'b0;
        state_nxt    = state;
        prio_b_nxt   = prio_b;
        beat_cnt_nxt = beat_cnt;

        if (state == IDLE) begin
            rearb = 1'b1;
        end else if (!cur_req) begin
            // abandoned burst: nothing presented, give the lane up
            rearb = 1'b1;
        end else if (beat && (cur_last || beat_cnt == LAST_CNT)) begin
            rearb = 1'b1;
        end

        if (rearb) begin
            beat_cnt_nxt = 8'd0;
            if (req_a && (!req_b || !prio_b)) begin
                state_nxt  = GRANT_A;
                prio_b_nxt = 1'b1;
            end else if (req_b) begin
                state_nxt  = GRANT_B;
                prio_b_nxt = 1'b0;
            end else begin
                state_nxt = IDLE;
            end
        end else if (beat) begin
            beat_cnt_nxt = beat_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            prio_b   <= 1'b0;
            beat_cnt <= 8'd0;
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            sel_b1   <= 1'b0;
            sel_b2   <= 1'b0;
        end else begin
            state    <= state_nxt;
            prio_b   <= prio_b_nxt;
            beat_cnt <= beat_cnt_nxt;
            gnt_a    <= (state_nxt == GRANT_A);
            gnt_b    <= (state_nxt == GRANT_B);
            sel_b1   <= (state_nxt == GRANT_B);
            sel_b2   <= (state_nxt == GRANT_B);
        end
    end

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Directed bench for mux_share_arbiter: MAX_BURST=4 instance plus a MAX_BURST=1 instance on shared inputs.
module tb_mux_share_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_a, last_a, req_b, last_b, ready;
    logic [7:0] data_a, data_b;

    logic       gnt_a0, gnt_b0, sel_b1_0, sel_b2_0, out_valid0;
    logic [7:0] out_data0;
    logic       gnt_a1, gnt_b1, sel_b1_1, sel_b2_1, out_valid1;
    logic [7:0] out_data1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_share_arbiter #(.WIDTH(8), .MAX_BURST(4)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_a(req_a), .data_a(data_a), .last_a(last_a),
        .req_b(req_b), .data_b(data_b), .last_b(last_b),
        .ready(ready),
        .gnt_a(gnt_a0), .gnt_b(gnt_b0), .sel_b1(sel_b1_0), .sel_b2(sel_b2_0),
        .out_valid(out_valid0), .out_data(out_data0)
    );

    mux_share_arbiter #(.WIDTH(8), .MAX_BURST(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .req_a(req_a), .data_a(data_a), .last_a(last_a),
        .req_b(req_b), .data_b(data_b), .last_b(last_b),
        .ready(ready),
        .gnt_a(gnt_a1), .gnt_b(gnt_b1), .sel_b1(sel_b1_1), .sel_b2(sel_b2_1),
        .out_valid(out_valid1), .out_data(out_data1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_b;

        reset  = 1'b1;
        req_a  = 1'b0;
        req_b  = 1'b0;
        last_a = 1'b0;
        last_b = 1'b0;
        ready  = 1'b1;
        data_a = 8'hA5;
        data_b = 8'h5A;

        // Reset state
        step();
        step();
        chk("rst_gnt_a", 32'(gnt_a0), 32'd0);
        chk("rst_gnt_b", 32'(gnt_b0), 32'd0);
        chk("rst_sel_b1", 32'(sel_b1_0), 32'd0);
        chk("rst_sel_b2", 32'(sel_b2_0), 32'd0);
        chk("rst_out_valid", 32'(out_valid0), 32'd0);
        chk("rst_out_data", 32'(out_data0), 32'hA5);
        chk("rst_mb1_gnt", 32'({gnt_a1, gnt_b1}), 32'd0);

        // A alone: granted from cycle 1, re-granted straight after the 4th beat
        reset = 1'b0;
        req_a = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("solo_a_gnt_a_c%0d", k), 32'(gnt_a0), 32'd1);
            chk($sformatf("solo_a_gnt_b_c%0d", k), 32'(gnt_b0), 32'd0);
            chk($sformatf("solo_a_valid_c%0d", k), 32'(out_valid0), 32'd1);
            chk($sformatf("solo_a_data_c%0d", k), 32'(out_data0), 32'hA5);
        end

        // Both held: A x4, B x4, A x4; MAX_BURST=1 instance alternates
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_a = 1'b1;
        req_b = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_b = (k >= 5 && k <= 8);
            chk($sformatf("tie_gnt_a_c%0d", k), 32'(gnt_a0), 32'(!exp_b));
            chk($sformatf("tie_gnt_b_c%0d", k), 32'(gnt_b0), 32'(exp_b));
            chk($sformatf("tie_sel_b1_c%0d", k), 32'(sel_b1_0), 32'(exp_b));
            chk($sformatf("tie_sel_b2_c%0d", k), 32'(sel_b2_0), 32'(exp_b));
            chk($sformatf("tie_data_c%0d", k), 32'(out_data0), exp_b ? 32'h5A : 32'hA5);
            chk($sformatf("mb1_gnt_b_c%0d", k), 32'(gnt_b1), 32'((k % 2) == 0));
            chk($sformatf("mb1_gnt_a_c%0d", k), 32'(gnt_a1), 32'((k % 2) == 1));
        end

        // B granted, one beat, then 10 stalled cycles with A waiting
        reset = 1'b1;
        req_a = 1'b0;
        req_b = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("stall_first_gnt_b", 32'(gnt_b0), 32'd1);
        step();
        chk("stall_after_beat1_gnt_b", 32'(gnt_b0), 32'd1);
        ready = 1'b0;
        req_a = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk($sformatf("stall_gnt_b_c%0d", k), 32'(gnt_b0), 32'd1);
            chk($sformatf("stall_gnt_a_c%0d", k), 32'(gnt_a0), 32'd0);
            chk($sformatf("stall_data_c%0d", k), 32'(out_data0), 32'h5A);
            chk($sformatf("stall_valid_c%0d", k), 32'(out_valid0), 32'd1);
        end
        ready = 1'b1;
        step();
        chk("resume_beat2_gnt_b", 32'(gnt_b0), 32'd1);
        step();
        chk("resume_beat3_gnt_b", 32'(gnt_b0), 32'd1);
        step();
        chk("resume_beat4_gnt_a", 32'(gnt_a0), 32'd1);
        chk("resume_beat4_gnt_b", 32'(gnt_b0), 32'd0);

        // A ends its burst early with last_a on beat 2
        reset = 1'b1;
        req_a = 1'b1;
        req_b = 1'b0;
        step();
        reset = 1'b0;
        step();
        chk("last_gnt_a_c1", 32'(gnt_a0), 32'd1);
        step();
        chk("last_gnt_a_c2", 32'(gnt_a0), 32'd1);
        last_a = 1'b1;
        req_b  = 1'b1;
        step();
        chk("last_handover_gnt_b", 32'(gnt_b0), 32'd1);
        chk("last_handover_gnt_a", 32'(gnt_a0), 32'd0);
        last_a = 1'b0;

        // Random traffic: grants exclusive, select pair tracks B grant
        for (int k = 0; k < 100; k++) begin
            req_a  = 1'($urandom_range(0, 1));
            req_b  = 1'($urandom_range(0, 1));
            last_a = 1'($urandom_range(0, 1));
            last_b = 1'($urandom_range(0, 1));
            ready  = 1'($urandom_range(0, 1));
            data_a = 8'($urandom_range(0, 255));
            data_b = 8'($urandom_range(0, 255));
            step();
            chk($sformatf("rand_excl0_c%0d", k), 32'(gnt_a0 & gnt_b0), 32'd0);
            chk($sformatf("rand_excl1_c%0d", k), 32'(gnt_a1 & gnt_b1), 32'd0);
            chk($sformatf("rand_sel0_c%0d", k), 32'({sel_b1_0, sel_b2_0}), 32'({gnt_b0, gnt_b0}));
            chk($sformatf("rand_out1_c%0d", k), 32'({out_valid1, out_data1}),
                32'({(gnt_a1 & req_a) | (gnt_b1 & req_b), gnt_b1 ? data_b : data_a}));
        end
        data_a = 8'hA5;
        data_b = 8'h5A;
        last_a = 1'b0;
        last_b = 1'b0;
        ready  = 1'b1;

        // Granted B drops its request: lane released to IDLE
        reset = 1'b1;
        req_a = 1'b0;
        req_b = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("drop_gnt_b", 32'(gnt_b0), 32'd1);
        req_b = 1'b0;
        #1;
        chk("drop_valid_low", 32'(out_valid0), 32'd0);
        step();
        chk("drop_idle_gnt", 32'({gnt_a0, gnt_b0}), 32'd0);

        // Reset mid-B-burst, then tie goes to A
        req_b = 1'b1;
        step();
        chk("mid_b_gnt_b", 32'(gnt_b0), 32'd1);
        step();
        reset = 1'b1;
        req_a = 1'b1;
        step();
        chk("mid_b_rst_gnt", 32'({gnt_a0, gnt_b0}), 32'd0);
        chk("mid_b_rst_sel", 32'({sel_b1_0, sel_b2_0}), 32'd0);
        chk("mid_b_rst_data", 32'(out_data0), 32'hA5);
        reset = 1'b0;
        step();
        chk("mid_b_tie_gnt_a", 32'(gnt_a0), 32'd1);
        chk("mid_b_tie_gnt_b", 32'(gnt_b0), 32'd0);

        // Reset mid-A-burst (prio had moved to B), tie still goes to A
        step();
        reset = 1'b1;
        step();
        chk("mid_a_rst_gnt", 32'({gnt_a0, gnt_b0}), 32'd0);
        reset = 1'b0;
        step();
        chk("mid_a_tie_gnt_a", 32'(gnt_a0), 32'd1);
        chk("mid_a_tie_gnt_b", 32'(gnt_b0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
